// File: rtl/axis_pkt_rx_buffer.sv
// AXI4-Stream packet receive buffer: captures one packet at a time into a
// local RAM, holds it for a consumer with random-access reads, and drops
// packets that do not fit in the buffer.
module axis_pkt_rx_buffer #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ID_W   = 8,
  parameter  int unsigned USER_W = 1,
  parameter  int unsigned DEPTH  = 256,
  localparam int unsigned KEEP_W = DATA_W / 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [ID_W-1:0]   s_tdest,
  input  logic [ID_W-1:0]   s_tid,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              pkt_valid,
  output logic [LW-1:0]     pkt_len,
  output logic [ID_W-1:0]   pkt_id,
  output logic [ID_W-1:0]   pkt_dest,
  output logic [USER_W-1:0] pkt_user,
  output logic [KEEP_W-1:0] pkt_last_keep,
  output logic              pkt_err,
  input  logic              pkt_ack,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              pkt_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_tready;
  logic                r_pkt_valid;
  logic                r_drop;
  logic                r_err;
  logic [LW-1:0]       r_count;
  logic [LW-1:0]       r_pkt_len;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_dest;
  logic [USER_W-1:0]   r_user;
  logic [KEEP_W-1:0]   r_last_keep;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_accept;
  logic                w_full;
  logic                w_mismatch;
  logic                w_wr_en;
  logic [AW-1:0]       w_wr_addr;
  logic                w_first;
  logic                w_count_inc;
  logic                w_set_err;
  logic                w_load_len;
  logic [LW-1:0]       w_new_len;
  logic                w_drop;

  assign w_accept   = s_tvalid & r_tready;
  assign w_full     = (r_count == LW'(DEPTH));
  assign w_mismatch = (s_tid != r_id) | (s_tdest != r_dest);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = s_tlast ? S_HOLD : S_RECV;
        end
      end
      S_RECV: begin
        if (w_accept && s_tlast) begin
          w_next_state = w_full ? S_IDLE : S_HOLD;
        end else if (w_accept && w_full) begin
          w_next_state = S_DROP;
        end
      end
      S_DROP: begin
        if (w_accept && s_tlast) begin
          w_next_state = S_IDLE;
        end
      end
      S_HOLD: begin
        if (pkt_ack) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_first     = 1'b0;
    w_count_inc = 1'b0;
    w_set_err   = 1'b0;
    w_load_len  = 1'b0;
    w_new_len   = LW'(1);
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_wr_en    = 1'b1;
          w_first    = 1'b1;
          w_load_len = s_tlast;
        end
      end
      S_RECV: begin
        if (w_accept) begin
          w_set_err = w_mismatch;
          if (!w_full) begin
            w_wr_en     = 1'b1;
            w_wr_addr   = AW'(r_count);
            w_count_inc = 1'b1;
            w_load_len  = s_tlast;
            w_new_len   = r_count + LW'(1);
          end else begin
            w_drop = s_tlast;
          end
        end
      end
      S_DROP: begin
        w_drop = w_accept & s_tlast;
      end
      default: ;
    endcase
  end

  // Handshake and packet status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tready    <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
      r_pkt_len   <= '0;
      r_id        <= '0;
      r_dest      <= '0;
      r_user      <= '0;
      r_last_keep <= '0;
    end else begin
      r_tready    <= (w_next_state != S_HOLD);
      r_pkt_valid <= (w_next_state == S_HOLD);
      r_drop      <= w_drop;
      if (w_first) begin
        r_count <= LW'(1);
        r_id    <= s_tid;
        r_dest  <= s_tdest;
        r_user  <= s_tuser;
        r_err   <= 1'b0;
      end else if (w_count_inc) begin
        r_count <= r_count + LW'(1);
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_load_len) begin
        r_pkt_len   <= w_new_len;
        r_last_keep <= s_tkeep;
      end
    end
  end

  // Packet buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= s_tdata;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign s_tready      = r_tready;
  assign pkt_valid     = r_pkt_valid;
  assign pkt_len       = r_pkt_len;
  assign pkt_id        = r_id;
  assign pkt_dest      = r_dest;
  assign pkt_user      = r_user;
  assign pkt_last_keep = r_last_keep;
  assign pkt_err       = r_err;
  assign pkt_drop      = r_drop;
  assign rd_data       = r_rd_data;

endmodule

// File: tb/tb_axis_pkt_rx_buffer.sv
// Bench for axis_pkt_rx_buffer: a DEPTH=256 and a DEPTH=4 instance share one
// stimulus bus; a packet-level model predicts held packets and drops.
module tb_axis_pkt_rx_buffer;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [3:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] d_tdata;
  logic [7:0]  d_tid, d_tdest;
  logic [3:0]  d_tkeep;
  logic        d_tlast;
  logic [0:0]  d_tuser;
  logic        d_tvalid, d_ack;
  logic [7:0]  d_rd_addr;

  logic        a_tready, a_pvalid, a_err, a_drop;
  logic [8:0]  a_len;
  logic [7:0]  a_id, a_dest;
  logic [0:0]  a_user;
  logic [3:0]  a_keep;
  logic [31:0] a_rd;
  logic        b_tready, b_pvalid, b_err, b_drop;
  logic [2:0]  b_len;
  logic [7:0]  b_id, b_dest;
  logic [0:0]  b_user;
  logic [3:0]  b_keep;
  logic [31:0] b_rd;

  logic        o_tready, o_pvalid, o_err, o_drop, o_user;
  logic [8:0]  o_len;
  logic [7:0]  o_id, o_dest;
  logic [3:0]  o_keep;
  logic [31:0] o_rd;

  int n_checks = 0;
  int n_errors = 0;

  beat_t       pkt[$];
  beat_t       mq[$];
  int          m_depth;
  bit          m_held;
  int          m_len;
  logic [7:0]  m_id, m_dest;
  logic        m_user;
  logic [3:0]  m_keep;
  bit          m_err;
  logic [31:0] m_data[$];
  int          m_drops = 0;
  int          drop_seen = 0;

  always #5 clk = ~clk;

  axis_pkt_rx_buffer dut_a (
    .clk(clk), .rst(rst),
    .s_tdata(d_tdata), .s_tdest(d_tdest), .s_tid(d_tid), .s_tkeep(d_tkeep),
    .s_tlast(d_tlast), .s_tuser(d_tuser), .s_tvalid(d_tvalid & ~sel),
    .s_tready(a_tready), .pkt_valid(a_pvalid), .pkt_len(a_len), .pkt_id(a_id),
    .pkt_dest(a_dest), .pkt_user(a_user), .pkt_last_keep(a_keep), .pkt_err(a_err),
    .pkt_ack(d_ack & ~sel), .rd_addr(d_rd_addr), .rd_data(a_rd), .pkt_drop(a_drop)
  );

  axis_pkt_rx_buffer #(.DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .s_tdata(d_tdata), .s_tdest(d_tdest), .s_tid(d_tid), .s_tkeep(d_tkeep),
    .s_tlast(d_tlast), .s_tuser(d_tuser), .s_tvalid(d_tvalid & sel),
    .s_tready(b_tready), .pkt_valid(b_pvalid), .pkt_len(b_len), .pkt_id(b_id),
    .pkt_dest(b_dest), .pkt_user(b_user), .pkt_last_keep(b_keep), .pkt_err(b_err),
    .pkt_ack(d_ack & sel), .rd_addr(d_rd_addr[1:0]), .rd_data(b_rd), .pkt_drop(b_drop)
  );

  always_comb begin
    if (sel) begin
      o_tready = b_tready; o_pvalid = b_pvalid; o_err = b_err; o_drop = b_drop;
      o_len = 9'(b_len); o_id = b_id; o_dest = b_dest; o_user = b_user[0];
      o_keep = b_keep; o_rd = b_rd;
    end else begin
      o_tready = a_tready; o_pvalid = a_pvalid; o_err = a_err; o_drop = a_drop;
      o_len = a_len; o_id = a_id; o_dest = a_dest; o_user = a_user[0];
      o_keep = a_keep; o_rd = a_rd;
    end
  end

  // Count drop pulse cycles on the selected instance
  always @(posedge clk) begin
    if (o_drop === 1'b1) drop_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic v, input int depth);
    sel = v;
    m_depth = depth;
    #1;
  endtask

  // Packet-level model: a finished packet is held iff it fits in the buffer
  function automatic void model_accept(input beat_t b);
    mq.push_back(b);
    if (b.last) begin
      if (mq.size() <= m_depth) begin
        m_held = 1'b1;
        m_len  = mq.size();
        m_id   = mq[0].id;
        m_dest = mq[0].dest;
        m_user = mq[0].user;
        m_keep = b.keep;
        m_err  = 1'b0;
        m_data.delete();
        foreach (mq[i]) begin
          m_data.push_back(mq[i].data);
          if (mq[i].id != mq[0].id || mq[i].dest != mq[0].dest) m_err = 1'b1;
        end
      end else begin
        m_drops++;
      end
      mq.delete();
    end
  endfunction

  task automatic present(input beat_t b);
    d_tdata  = b.data;
    d_tid    = b.id;
    d_tdest  = b.dest;
    d_tkeep  = b.keep;
    d_tuser  = b.user;
    d_tlast  = b.last;
    d_tvalid = 1'b1;
  endtask

  task automatic send_beat(input beat_t b, input int maxgap);
    int g;
    bit done;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    if (g > 0) begin
      d_tvalid = 1'b0;
      repeat (g) @(negedge clk);
    end
    present(b);
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (o_tready === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    check("beat_accept_timeout", 64'(done), 64'(1));
    if (done) model_accept(b);
  endtask

  task automatic send_pkt(input int maxgap);
    foreach (pkt[i]) send_beat(pkt[i], maxgap);
    d_tvalid = 1'b0;
  endtask

  task automatic add_beat(input logic [31:0] data, input logic [7:0] id,
                          input logic [7:0] dest, input logic [3:0] keep,
                          input logic user, input logic last);
    beat_t b;
    b.data = data; b.id = id; b.dest = dest; b.keep = keep; b.user = user; b.last = last;
    pkt.push_back(b);
  endtask

  task automatic rand_pkt(input int maxlen);
    int n;
    logic [7:0] id0, dest0;
    pkt.delete();
    n     = int'($urandom_range(maxlen, 1));
    id0   = 8'($urandom);
    dest0 = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      add_beat($urandom,
               ($urandom_range(5, 0) == 0) ? 8'($urandom) : id0,
               ($urandom_range(7, 0) == 0) ? 8'($urandom) : dest0,
               4'($urandom), 1'($urandom), (i == n - 1));
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_model_held"}, 64'(m_held), 64'(1));
    check({tag, "_valid"}, 64'(o_pvalid), 64'(1));
    check({tag, "_tready"}, 64'(o_tready), 64'(0));
    check({tag, "_len"}, 64'(o_len), 64'(m_len));
    check({tag, "_id"}, 64'(o_id), 64'(m_id));
    check({tag, "_dest"}, 64'(o_dest), 64'(m_dest));
    check({tag, "_user"}, 64'(o_user), 64'(m_user));
    check({tag, "_keep"}, 64'(o_keep), 64'(m_keep));
    check({tag, "_err"}, 64'(o_err), 64'(m_err));
  endtask

  task automatic read_back(input string tag);
    for (int i = 0; i < m_len; i++) begin
      d_rd_addr = 8'(i);
      @(negedge clk);
      check({tag, "_rd"}, 64'(o_rd), 64'(m_data[i]));
    end
  endtask

  task automatic ack_pkt(input string tag);
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    m_held = 1'b0;
    check({tag, "_valid_after_ack"}, 64'(o_pvalid), 64'(0));
    check({tag, "_tready_after_ack"}, 64'(o_tready), 64'(1));
  endtask

  task automatic check_outcome(input string tag);
    if (m_held) begin
      check_fields(tag);
      read_back(tag);
      ack_pkt(tag);
    end else begin
      check({tag, "_dropped_valid"}, 64'(o_pvalid), 64'(0));
    end
    repeat (2) @(negedge clk);
    check({tag, "_drop_count"}, 64'(drop_seen), 64'(m_drops));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; m_depth = 256; m_held = 1'b0;
    d_tdata = '0; d_tid = '0; d_tdest = '0; d_tkeep = '0; d_tlast = 1'b0;
    d_tuser = '0; d_tvalid = 1'b0; d_ack = 1'b0; d_rd_addr = '0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    set_sel(1'b0, 256);
    check("rst_a_tready", 64'(o_tready), 64'(0));
    check("rst_a_valid", 64'(o_pvalid), 64'(0));
    check("rst_a_drop", 64'(o_drop), 64'(0));
    check("rst_a_err", 64'(o_err), 64'(0));
    check("rst_a_len", 64'(o_len), 64'(0));
    check("rst_a_id", 64'(o_id), 64'(0));
    check("rst_a_dest", 64'(o_dest), 64'(0));
    check("rst_a_user", 64'(o_user), 64'(0));
    check("rst_a_keep", 64'(o_keep), 64'(0));
    set_sel(1'b1, 4);
    check("rst_b_tready", 64'(o_tready), 64'(0));
    check("rst_b_valid", 64'(o_pvalid), 64'(0));
    check("rst_b_len", 64'(o_len), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_b_tready", 64'(o_tready), 64'(1));
    set_sel(1'b0, 256);
    check("post_rst_a_tready", 64'(o_tready), 64'(1));

    // Ack while idle is ignored
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_tready", 64'(o_tready), 64'(1));
    check("idle_ack_valid", 64'(o_pvalid), 64'(0));

    // Single-beat packet
    pkt.delete();
    add_beat(32'hA5A5A5A5, 8'd3, 8'd7, 4'hF, 1'b1, 1'b1);
    send_pkt(0);
    check_outcome("single");

    // Five beats with gaps, short last keep
    pkt.delete();
    for (int i = 1; i <= 5; i++) add_beat(32'(i), 8'd4, 8'd9, (i == 5) ? 4'h3 : 4'hF, 1'b0, (i == 5));
    send_pkt(3);
    check_outcome("five");

    // tid changes mid-packet, then a clean packet
    pkt.delete();
    for (int i = 1; i <= 4; i++) add_beat(32'(i + 16), (i == 3) ? 8'd2 : 8'd1, 8'd5, 4'hF, 1'b0, (i == 4));
    send_pkt(1);
    check("tidchg_model_err", 64'(m_err), 64'(1));
    check_outcome("tidchg");
    pkt.delete();
    for (int i = 1; i <= 3; i++) add_beat(32'(i + 32), 8'd1, 8'd5, 4'hF, 1'b0, (i == 3));
    send_pkt(1);
    check_outcome("clean");

    // Back-to-back packets with tvalid held high across the hold
    pkt.delete();
    for (int i = 0; i < 3; i++) add_beat($urandom, 8'h11, 8'h22, 4'hF, 1'b0, (i == 2));
    foreach (pkt[i]) send_beat(pkt[i], 0);
    pkt.delete();
    for (int i = 0; i < 4; i++) add_beat($urandom, 8'h33, 8'h44, 4'h7, 1'b1, (i == 3));
    present(pkt[0]);
    check_fields("b2b_p1");
    read_back("b2b_p1");
    check("b2b_hold_tready", 64'(o_tready), 64'(0));
    d_ack = 1'b1;
    @(negedge clk);
    d_ack = 1'b0;
    m_held = 1'b0;
    check("b2b_tready_after_ack", 64'(o_tready), 64'(1));
    check("b2b_valid_after_ack", 64'(o_pvalid), 64'(0));
    @(negedge clk);
    model_accept(pkt[0]);
    for (int i = 1; i < 4; i++) send_beat(pkt[i], 0);
    d_tvalid = 1'b0;
    check_outcome("b2b_p2");

    // DEPTH=4 boundaries: exact fit, one over, far over, then recovery
    set_sel(1'b1, 4);
    pkt.delete();
    for (int i = 0; i < 4; i++) add_beat(32'(i + 100), 8'd6, 8'd6, 4'hC, 1'b0, (i == 3));
    send_pkt(1);
    check_outcome("d4_fit");
    pkt.delete();
    for (int i = 0; i < 5; i++) add_beat(32'(i + 200), 8'd6, 8'd6, 4'hF, 1'b0, (i == 4));
    send_pkt(0);
    check_outcome("d4_over1");
    pkt.delete();
    for (int i = 0; i < 6; i++) add_beat(32'(i + 300), 8'd6, 8'd6, 4'hF, 1'b0, (i == 5));
    send_pkt(2);
    check_outcome("d4_over2");
    pkt.delete();
    for (int i = 0; i < 2; i++) add_beat(32'(i + 400), 8'd8, 8'd9, 4'h1, 1'b1, (i == 1));
    send_pkt(0);
    check("d4_after_drop_len", 64'(m_len), 64'(2));
    check_outcome("d4_after_drop");

    // Randomized packets on both depths
    for (int k = 0; k < 15; k++) begin
      rand_pkt(6);
      send_pkt(2);
      check_outcome("rand_d4");
    end
    set_sel(1'b0, 256);
    for (int k = 0; k < 8; k++) begin
      rand_pkt(12);
      send_pkt(2);
      check_outcome("rand_d256");
    end

    // Reset on beat 3 of 8: beat 3 is lost, beats 4..8 form a new packet
    pkt.delete();
    for (int i = 1; i <= 8; i++) add_beat(32'(i + 32'h100), 8'd2, 8'd3, 4'hF, 1'b0, (i == 8));
    send_beat(pkt[0], 0);
    send_beat(pkt[1], 0);
    present(pkt[2]);
    check("rstmid_tready_pre", 64'(o_tready), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    mq.delete();
    m_held = 1'b0;
    d_tvalid = 1'b0;
    check("rstmid_tready_in_rst", 64'(o_tready), 64'(0));
    check("rstmid_valid_in_rst", 64'(o_pvalid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 3; i < 8; i++) begin
      send_beat(pkt[i], 1);
      if (i < 7) check("rstmid_valid_before_last", 64'(o_pvalid), 64'(0));
    end
    d_tvalid = 1'b0;
    check("rstmid_model_len", 64'(m_len), 64'(5));
    check_outcome("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rx_buffer.md
Name: axis_pkt_rx_buffer

Overview:
AXI4-Stream slave (receiver) end of the team's axis interface: accepts one packet at a time into an internal buffer and holds it for a local consumer. The consumer reads the buffer through a random-access read port and releases it with an ack. Packets longer than the buffer are dropped whole. Sits between an axis_if slave_mp connection and register/CPU-side or DMA-side logic.

Parameters:
DATA_W, 32, tdata width in bits; multiple of 8
ID_W, 8, tid/tdest width
USER_W, 1, tuser width; must be at least 1
DEPTH, 256, buffer depth in beats; power of 2, at least 2
Derived: KEEP_W = DATA_W/8, AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
s_tdata  in  DATA_W  stream data
s_tdest  in  ID_W  stream destination
s_tid  in  ID_W  stream id
s_tkeep  in  KEEP_W  byte enables
s_tlast  in  1  end of packet
s_tuser  in  USER_W  sideband
s_tvalid  in  1  beat valid
s_tready  out  1  beat accept
pkt_valid  out  1  complete packet held in buffer
pkt_len  out  LW  packet length in beats, 1..DEPTH
pkt_id  out  ID_W  tid of first beat
pkt_dest  out  ID_W  tdest of first beat
pkt_user  out  USER_W  tuser of first beat
pkt_last_keep  out  KEEP_W  tkeep of last beat
pkt_err  out  1  tid or tdest changed within the packet
pkt_ack  in  1  consumer releases buffer; ignored unless pkt_valid
rd_addr  in  AW  beat index to read
rd_data  out  DATA_W  buffer[rd_addr], registered, 1-cycle latency
pkt_drop  out  1  one-cycle pulse when an oversize packet finishes dropping

Behaviour:
- Accept = s_tvalid & s_tready. tkeep of non-last beats is not checked.
- States: IDLE, RECV, DROP, HOLD.
- s_tready = 1 in IDLE, RECV and DROP. s_tready = 0 in HOLD and while rst is asserted. s_tready is a registered state decode with no combinational path from s_tvalid.
- IDLE, on accept:
  - Write the beat to buffer[0], count = 1.
  - Capture tid, tdest and tuser; clear the error flag.
  - If tlast: go to HOLD with pkt_len = 1 and pkt_last_keep = tkeep. Otherwise go to RECV.
- RECV, on accept:
  - If count < DEPTH: write buffer[count], count++.
  - If tid or tdest differs from the captured value: set the error flag, which stays set until the packet is released.
  - If tlast and count < DEPTH: go to HOLD with pkt_len = count+1.
  - If count == DEPTH: the beat is not written. If tlast, pulse pkt_drop and go to IDLE. Otherwise go to DROP.
  - A packet of exactly DEPTH beats is held; a packet of DEPTH+1 or more beats is dropped.
- DROP: accept and discard beats. On the tlast beat, pulse pkt_drop the next cycle and go to IDLE.
- HOLD:
  - pkt_valid = 1; pkt_len, pkt_id, pkt_dest, pkt_user, pkt_last_keep and pkt_err are stable.
  - pkt_ack = 1 moves to IDLE. pkt_valid falls and s_tready rises on the next cycle, so the earliest next accept is 1 cycle after the ack.
- The packet status outputs (pkt_len, pkt_id, pkt_dest, pkt_user, pkt_last_keep, pkt_err) are registered. Their values while pkt_valid = 0 are don't-care but must be deterministic.
- Read port: rd_data is valid the cycle after rd_addr is applied, in any state. Reads at addresses >= pkt_len return stale data. The buffer maps to inferred simple dual-port RAM, one write port and one read port.
- pkt_ack outside HOLD has no effect.
- Reset:
  - State goes to IDLE; s_tready = 0 during reset and 1 the cycle after.
  - pkt_valid, pkt_drop, pkt_err, pkt_len, pkt_id, pkt_dest, pkt_user and pkt_last_keep all reset to 0.
  - rd_data reset value is undefined, since it comes from RAM.
  - Reset mid-packet discards the partial packet; the remaining beats of that packet are then received as a new packet.
- No combinational path from any input to s_tready or pkt_valid.

Test Plan:
- Single-beat packet: tdata=0xA5A5A5A5, tid=3, tdest=7, tkeep=0xF, tlast=1 -> next cycle pkt_valid=1, pkt_len=1, pkt_id=3, pkt_dest=7, s_tready=0; rd_addr=0 gives 0xA5A5A5A5 one cycle later; pkt_ack -> pkt_valid=0 and s_tready=1 next cycle.
- 5-beat packet with data 1..5, last tkeep=0x3, random tvalid gaps -> pkt_len=5, pkt_last_keep=0x3; reading addresses 0..4 returns 1..5; pkt_err=0.
- DEPTH=4 with a 4-beat packet -> held, pkt_len=4. DEPTH=4 with a 6-beat packet -> all 6 beats accepted, pkt_drop pulses exactly once, pkt_valid stays 0, then a following 2-beat packet is held with pkt_len=2.
- tid changes from 1 to 2 on beat 3 of 4 -> pkt_err=1 and pkt_id=1. After ack, a clean packet gives pkt_err=0.
- Back-to-back packets with tvalid held high: while HOLD, s_tready=0 and no beat is lost; ack in cycle N -> the second packet's first beat is accepted in cycle N+1.
- rst asserted on beat 3 of an 8-beat packet -> s_tready=0 during reset, IDLE afterwards; the remaining 5 beats are held as a packet with pkt_len=5 and pkt_valid=0 until their tlast.
